// File: rtl/sum_acc_pkg.sv
// sum_acc_pkg: shared state encoding and default widths for the sum accumulator.
package sum_acc_pkg;
  localparam int DATA_W = 32;
  localparam int ACC_W = 40;
  localparam int ADDEND_W = DATA_W + 1;
  typedef enum logic {ACCUM, HOLD} state_t;
endpackage

// File: rtl/sum_accumulator.sv
// sum_accumulator: sums BATCH adder {cout,sum} results and holds the total until taken.
// Define SUM_ACCUMULATOR_SATURATE_EN to clamp at all-ones instead of wrapping.
module sum_accumulator import sum_acc_pkg::*; #(
  parameter int DATA_W = sum_acc_pkg::DATA_W,
  parameter int ACC_W = sum_acc_pkg::ACC_W,
  parameter int BATCH = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            sum,
  input  logic                         cout,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_W-1:0]             acc_out,
  output logic                         overflow,
  output logic [$clog2(BATCH+1)-1:0]   count
);
  localparam int CNT_W = $clog2(BATCH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BATCH - 1);
  state_t state, state_nx;
  logic [ACC_W-1:0] acc_nx;
  logic [ACC_W:0] addend, raw;
  logic ovf_nx, take;
  logic [CNT_W-1:0] cnt_nx;
  assign in_ready = state == ACCUM;
  assign out_valid = state == HOLD;
  assign take = in_valid && in_ready;
  assign addend = (ACC_W + 1)'({cout, sum});
  assign raw = {1'b0, acc_out} + addend;
  always_comb begin
    state_nx = state;
    acc_nx = acc_out;
    ovf_nx = overflow;
    cnt_nx = count;
    if (take) begin
`ifdef SUM_ACCUMULATOR_SATURATE_EN
      acc_nx = raw[ACC_W] ? '1 : raw[ACC_W-1:0];
`else
      acc_nx = raw[ACC_W-1:0];
`endif
      ovf_nx = overflow | raw[ACC_W];
      cnt_nx = count + 1'b1;
      state_nx = count == LAST ? HOLD : ACCUM;
    end else if (out_valid && out_ready) begin
      acc_nx = '0;
      ovf_nx = 1'b0;
      cnt_nx = '0;
      state_nx = ACCUM;
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ACCUM;
      acc_out <= '0;
      overflow <= 1'b0;
      count <= '0;
    end else begin
      state <= state_nx;
      acc_out <= acc_nx;
      overflow <= ovf_nx;
      count <= cnt_nx;
    end
  end
endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: directed plus randomized checks of sum_accumulator against a transaction model.
module tb_sum_accumulator;
  logic clk = 0, resetn = 0, in_valid = 0, cout = 0, out_ready = 0;
  logic [31:0] sum = 0;
  logic rdy_a, ov_a, of_a, rdy_b, ov_b, of_b, rdy_c, ov_c, of_c;
  logic [39:0] acc_a, acc_c;
  logic [33:0] acc_b;
  logic [2:0] cnt_a, cnt_b;
  logic [0:0] cnt_c;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  sum_accumulator dut_a (.clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(rdy_a), .sum(sum),
    .cout(cout), .out_valid(ov_a), .out_ready(out_ready), .acc_out(acc_a), .overflow(of_a), .count(cnt_a));
  sum_accumulator #(.ACC_W(34)) dut_b (.clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(rdy_b),
    .sum(sum), .cout(cout), .out_valid(ov_b), .out_ready(out_ready), .acc_out(acc_b), .overflow(of_b), .count(cnt_b));
  sum_accumulator #(.BATCH(1)) dut_c (.clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(rdy_c),
    .sum(sum), .cout(cout), .out_valid(ov_c), .out_ready(out_ready), .acc_out(acc_c), .overflow(of_c), .count(cnt_c));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic beat(input logic v, input logic [31:0] s, input logic c);
    in_valid = v;
    sum = s;
    cout = c;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    resetn = 0;
    in_valid = 0;
    out_ready = 0;
    @(posedge clk);
    #1;
    resetn = 1;
  endtask
  function automatic logic [63:0] model_acc(input longint unsigned t, input int w);
    longint unsigned lim = 64'(1) << w;
`ifdef SUM_ACCUMULATOR_SATURATE_EN
    return t >= lim ? lim - 1 : t;
`else
    return t % lim;
`endif
  endfunction
  function automatic logic model_ovf(input longint unsigned t, input int w);
    return t >= (64'(1) << w);
  endfunction
  logic [15:0] pa[4] = '{16'had30, 16'hdf26, 16'hedf9, 16'hefad};
  logic [15:0] pb[4] = '{16'heff5, 16'hfed3, 16'hdef8, 16'h123d};
  logic pc[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic gap[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  longint unsigned tot;
  logic [32:0] r;
  logic v, c;
  logic [31:0] s;
  int n, k;
  initial begin
    do_reset();
    chk("rst_ready", rdy_a, 1);
    chk("rst_valid", ov_a, 0);
    chk("rst_acc", acc_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_ovf", of_a, 0);
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      r = 33'(pa[i]) + 33'(pb[i]) + 33'(pc[i]);
      tot += 64'(r);
      chk("plan_valid_early", ov_a, 0);
      beat(1, r[31:0], r[32]);
      chk("plan_cnt", cnt_a, i + 1);
    end
    chk("plan_total_model", tot, 64'h649fb);
    chk("plan_valid", ov_a, 1);
    chk("plan_acc", acc_a, 64'h649fb);
    chk("plan_ovf", of_a, 0);
    chk("plan_ready", rdy_a, 0);
    for (int i = 0; i < 5; i++) beat(1, 32'h1234, 1);
    chk("hold_acc", acc_a, 64'h649fb);
    chk("hold_cnt", cnt_a, 4);
    chk("hold_valid", ov_a, 1);
    out_ready = 1;
    beat(1, 32'h7, 0);
    out_ready = 0;
    chk("take_acc", acc_a, 0);
    chk("take_cnt", cnt_a, 0);
    chk("take_ready", rdy_a, 1);
    chk("take_valid", ov_a, 0);
    beat(1, 32'h7, 0);
    chk("next_cnt", cnt_a, 1);
    chk("next_acc", acc_a, 7);
    do_reset();
    for (int i = 0; i < 4; i++) beat(1, 32'hffffffff, 1);
    chk("w34_acc", acc_b, model_acc(4 * 64'h1ffffffff, 34));
`ifdef SUM_ACCUMULATOR_SATURATE_EN
    chk("w34_acc_const", acc_b, 64'h3ffffffff);
`else
    chk("w34_acc_const", acc_b, 64'h3fffffffc);
`endif
    chk("w34_ovf", of_b, 1);
    chk("w34_valid", ov_b, 1);
    do_reset();
    n = 0;
    for (int i = 0; i < 7 && n < 4; i++) begin
      beat(gap[i], 32'h1, 0);
      if (gap[i]) n++;
      chk("gap_valid", ov_a, n == 4);
      chk("gap_cnt", cnt_a, n);
    end
    chk("gap_acc", acc_a, 4);
    do_reset();
    beat(1, 32'h55, 1);
    beat(1, 32'h66, 0);
    resetn = 0;
    beat(0, 0, 0);
    resetn = 1;
    chk("mid_rst_cnt", cnt_a, 0);
    chk("mid_rst_acc", acc_a, 0);
    for (int i = 0; i < 4; i++) beat(1, 32'h10, 0);
    chk("post_rst_acc", acc_a, 64'h40);
    chk("post_rst_valid", ov_a, 1);
    resetn = 0;
    beat(1, 32'h10, 0);
    resetn = 1;
    chk("hold_rst_valid", ov_a, 0);
    chk("hold_rst_ready", rdy_a, 1);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      beat(1, 32'h5, 1);
      chk("b1_valid", ov_c, 1);
      chk("b1_acc", acc_c, 64'h100000005);
      chk("b1_cnt", cnt_c, 1);
      out_ready = 1;
      beat(1, 32'h5, 1);
      out_ready = 0;
      chk("b1_take_valid", ov_c, 0);
      chk("b1_take_cnt", cnt_c, 0);
      chk("b1_take_acc", acc_c, 0);
    end
    do_reset();
    for (int b = 0; b < 12; b++) begin
      tot = 0;
      n = 0;
      while (n < 4) begin
        v = $urandom_range(0, 3) != 0;
        s = $urandom;
        c = 1'($urandom_range(0, 1));
        beat(v, s, c);
        if (v) begin
          tot += 64'({c, s});
          n++;
        end
        chk("rnd_cnt", cnt_a, n);
        chk("rnd_valid", ov_a, n == 4);
        chk("rnd_acc40", acc_a, model_acc(tot, 40));
        chk("rnd_ovf40", of_a, model_ovf(tot, 40));
        chk("rnd_acc34", acc_b, model_acc(tot, 34));
        chk("rnd_ovf34", of_b, model_ovf(tot, 34));
      end
      k = $urandom_range(0, 3);
      for (int i = 0; i < k; i++) beat(1'($urandom_range(0, 1)), $urandom, 1);
      chk("rnd_hold_acc", acc_b, model_acc(tot, 34));
      chk("rnd_hold_ready", rdy_a, 0);
      out_ready = 1;
      beat(1'($urandom_range(0, 1)), $urandom, 1);
      out_ready = 0;
      chk("rnd_take_cnt", cnt_a, 0);
      chk("rnd_take_acc", acc_b, 0);
      chk("rnd_take_ovf", of_b, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
